dsm_feeder: RTL
===============

// Module: dsm_feeder
// PURPOSE
//  Sample-rate scheduler in front of dsm. Buffers upstream PCM through a
//  valid/ready FIFO and presents one sample every OSR clk cycles.
//  Applies a linear soft ramp (mute/unmute) so start and stop produce no pops.
//  Flags FIFO underrun.
//  Sits between the PCM source and dsm.pcm; pcm_out drives dsm.pcm directly.
// PARAMETERS
//  OSR        64  clk cycles per PCM sample; power of 2, >=4
//  LOG2_OSR   6   log2(OSR)
//  FIFO_DEPTH 4   sample FIFO entries; power of 2
//  GAIN_BITS  8   ramp resolution; GAIN_MAX = 1<<GAIN_BITS; ramp takes GAIN_MAX ticks
// PORTS
//  clk       in   1            system clock, CLK_FREQ (same clock as dsm)
//  rst       in   1            synchronous reset, active-high
//  en        in   1            play request; 1 = ramp up / run, 0 = ramp down / idle
//  in_data   in   `PCM_QUANT   signed PCM sample
//  in_valid  in   1            in_data valid
//  in_ready  out  1            FIFO can accept; push = in_valid & in_ready
//  pcm_out   out  `PCM_QUANT   signed sample to dsm, registered
//  tick      out  1            one-clk strobe at each sample boundary
//  busy      out  1            state != IDLE
//  underrun  out  1            one-clk pulse: tick while playing with FIFO empty
// BEHAVIOUR
//  Reset values: pcm_out=0, tick=0, underrun=0, busy=0, in_ready=0.
//  Reset state: IDLE, gain=0, cur=0, FIFO empty, tick counter cnt=0.
//  In-reset outputs: in_ready is held 0 while rst=1.
//  Reset mid-operation: abandons any ramp immediately; no ramp-down.
//  tick: cnt counts 0..OSR-1 and wraps; tick=1 while cnt==OSR-1.
//    First tick after reset release: OSR cycles after release.
//  FIFO: in_ready = !full (and !rst). Pushes are accepted in every state,
//    which allows prefill in IDLE. A full FIFO refuses a push even if it pops
//    in the same cycle. An empty FIFO cannot pop a word pushed in the same cycle.
//  Tick edge in a non-IDLE state:
//    - FIFO non-empty: pop into cur.
//    - FIFO empty: cur holds; underrun pulses next cycle, in any non-IDLE state.
//  FSM (transitions on a clk edge):
//    IDLE      : en=1 -> RAMP_UP. gain=0, cur=0, no pops.
//    RAMP_UP   : on tick, gain+=1. When gain reaches GAIN_MAX -> RUN.
//                en=0 -> RAMP_DOWN with gain retained.
//    RUN       : gain=GAIN_MAX. en=0 -> RAMP_DOWN.
//    RAMP_DOWN : on tick, gain-=1. When gain reaches 0 -> IDLE; FIFO flushed
//                and cur=0 on that same edge. en=1 -> RAMP_UP with gain retained.
//  en is sampled every clk; an en toggle takes effect on the next edge.
//  Arithmetic:
//    - p = cur * {1'b0,gain}, signed, width PCM_QUANT+GAIN_BITS+1.
//    - q = p >>> GAIN_BITS (arithmetic; floor). GAIN_MAX gives q = cur exactly.
//  Clamp: q = -2^(PCM_QUANT-1) becomes -(2^(PCM_QUANT-1)-1), because dsm
//    feedback is symmetric.
//  pcm_out <= clamped q every clk.
//  Latency: tick edge updates cur/gain; pcm_out reflects them on the next edge.
//  busy is registered state != IDLE.
// STRUCTURE
//  def.v holds `PCM_QUANT and the state encodings:
//    `FEED_IDLE=2'd0, `FEED_UP=2'd1, `FEED_RUN=2'd2, `FEED_DOWN=2'd3.
//  One sub-module, pcm_fifo (params WIDTH, DEPTH):
//    ports clk, rst, flush, push, din, pop, dout, full, empty.
//    Synchronous flush; flush takes priority over push.
//  The FSM, tick counter, gain and the multiply/clamp datapath live in
//  dsm_feeder itself.
// TESTING (PCM_QUANT=16, OSR=4, GAIN_BITS=2, FIFO_DEPTH=4 unless noted)
//  1 Prefill: rst, en=0, push 5 words back-to-back.
//    -> 4 accepted; in_ready=0 after the 4th; pcm_out=0, busy=0, no underrun.
//  2 Ramp-up: prefill 4096 x4, en=1, keep pushing 4096.
//    -> over successive ticks pcm_out = 1024, 2048, 3072, 4096, then RUN.
//  3 Underrun: in RUN, stop pushing.
//    -> after the FIFO drains, underrun is a 1-clk pulse per tick and
//       pcm_out holds 4096.
//  4 Abort ramp: en drops when gain=2 in RAMP_UP.
//    -> RAMP_DOWN; pcm_out 1024 then 0; IDLE; FIFO empty; in_ready=1; busy=0.
//  5 Clamp/sign: RUN, push -32768 and -3.
//    -> pcm_out -32767 and -3; at gain=1, -3 gives pcm_out -1 (floor of -0.75).
//  6 Reset in RUN.
//    -> next cycle pcm_out=0, busy=0, in_ready=0 during rst.
//    -> after release, first tick exactly 4 clks later, FIFO empty.

Source files
------------

// File: rtl/dsm_feeder_pkg.sv
// Shared types for the PCM feeder: sample width, feeder states and the
// symmetric clamp applied before samples reach the modulator.
package dsm_feeder_pkg;

   localparam int unsigned PCM_QUANT = 16;

   typedef logic signed [PCM_QUANT-1:0] pcm_t;

   typedef enum logic [1:0] {
      FEED_IDLE = 2'd0,
      FEED_UP   = 2'd1,
      FEED_RUN  = 2'd2,
      FEED_DOWN = 2'd3
   } feed_state_e;

   localparam pcm_t PCM_MIN     = {1'b1, {(PCM_QUANT-1){1'b0}}};
   localparam pcm_t PCM_SYM_MIN = {1'b1, {(PCM_QUANT-2){1'b0}}, 1'b1};

   // Modulator feedback is symmetric, so the most negative code is not usable.
   function automatic pcm_t sym_clamp(input pcm_t x);
      return (x == PCM_MIN) ? PCM_SYM_MIN : x;
   endfunction

endpackage

// File: rtl/dsm_feeder_fifo.sv
// Small sample FIFO with synchronous flush; flush wins over push and pop.
module pcm_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr] <= din;
   end

endmodule

// File: rtl/dsm_feeder.sv
// Sample-rate scheduler in front of the modulator: buffers PCM, releases one
// sample per OSR clocks and applies a linear gain ramp on start and stop.
module dsm_feeder
   import dsm_feeder_pkg::*;
#(
   parameter int unsigned OSR        = 64,
   parameter int unsigned LOG2_OSR   = 6,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned GAIN_BITS  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic signed [PCM_QUANT-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic signed [PCM_QUANT-1:0] pcm_out,
   output logic                        tick,
   output logic                        busy,
   output logic                        underrun
);

   localparam int unsigned GW = GAIN_BITS + 1;
   localparam int unsigned PW = PCM_QUANT + GAIN_BITS + 1;
   localparam logic [GW-1:0] GAIN_MAX = {1'b1, {GAIN_BITS{1'b0}}};

   feed_state_e          state;
   feed_state_e          state_nxt;
   logic [LOG2_OSR-1:0]  cnt;
   logic [LOG2_OSR-1:0]  cnt_nxt;
   logic [GW-1:0]        gain;
   logic [GW-1:0]        gain_nxt;
   pcm_t                 cur;
   pcm_t                 cur_nxt;
   logic                 pop_c;
   logic                 flush_c;
   logic                 underrun_nxt;
   logic                 push_c;
   logic                 full;
   logic                 empty;
   pcm_t                 fifo_dout;
   logic signed [PW-1:0] prod_c;
   logic signed [PW-1:0] scaled_c;
   pcm_t                 level_c;

   assign in_ready = !full && !rst;
   assign push_c   = in_valid && in_ready;
   assign cnt_nxt  = cnt + LOG2_OSR'(1);

   pcm_fifo #(
      .WIDTH (PCM_QUANT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush_c),
      .push  (push_c),
      .din   (in_data),
      .pop   (pop_c),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   // Gain scaling: floor(cur * gain / GAIN_MAX), then symmetric clamp.
   always_comb begin
      prod_c   = PW'(cur) * PW'($signed({1'b0, gain}));
      scaled_c = prod_c >>> GAIN_BITS;
      level_c  = sym_clamp(PCM_QUANT'(scaled_c));
   end

   always_comb begin
      state_nxt    = state;
      gain_nxt     = gain;
      cur_nxt      = cur;
      pop_c        = 1'b0;
      flush_c      = 1'b0;
      underrun_nxt = 1'b0;

      if (state != FEED_IDLE && tick) begin
         if (!empty) begin
            pop_c   = 1'b1;
            cur_nxt = fifo_dout;
         end else begin
            underrun_nxt = 1'b1;
         end
      end

      unique case (state)
         FEED_IDLE: begin
            gain_nxt = '0;
            cur_nxt  = '0;
            if (en) state_nxt = FEED_UP;
         end
         FEED_UP: begin
            if (!en) begin
               state_nxt = FEED_DOWN;
            end else if (tick) begin
               gain_nxt = gain + GW'(1);
               if (gain_nxt == GAIN_MAX) state_nxt = FEED_RUN;
            end
         end
         FEED_RUN: begin
            gain_nxt = GAIN_MAX;
            if (!en) state_nxt = FEED_DOWN;
         end
         FEED_DOWN: begin
            if (en) begin
               state_nxt = FEED_UP;
            end else begin
               if (tick && gain != '0) gain_nxt = gain - GW'(1);
               // Reaching silence returns to idle with nothing stale left queued.
               if (gain_nxt == '0) begin
                  state_nxt = FEED_IDLE;
                  flush_c   = 1'b1;
                  cur_nxt   = '0;
               end
            end
         end
         default: state_nxt = FEED_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FEED_IDLE;
         cnt      <= '0;
         gain     <= '0;
         cur      <= '0;
         tick     <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
         pcm_out  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         gain     <= gain_nxt;
         cur      <= cur_nxt;
         tick     <= (cnt_nxt == LOG2_OSR'(OSR - 1));
         busy     <= (state_nxt != FEED_IDLE);
         underrun <= underrun_nxt;
         pcm_out  <= level_c;
      end
   end

endmodule
